// File: rtl/uart_rx_fifo_writer.sv
// UART receiver (8N1 by default) feeding a synchronous FIFO.
// Each good byte produces a one-cycle write strobe; bad stop bits and drops while full are flagged.
module uart_rx_fifo_writer #(
  parameter int unsigned DWIDTH       = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rxd,
  input  logic              full,
  output logic              wr,
  output logic [DWIDTH-1:0] data,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW   = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic [1:0]        r_sync;
  logic [2:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bidx;
  logic [DWIDTH-1:0] r_shift;
  logic [DWIDTH-1:0] r_data;
  logic              r_wr;
  logic              r_frame_err;
  logic              r_overrun;
  logic              r_busy;

  logic              w_rxs;
  logic              w_bit_end;
  logic [2:0]        w_state_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [BW-1:0]     w_bidx_nxt;
  logic [DWIDTH-1:0] w_shift_nxt;
  logic [DWIDTH-1:0] w_data_nxt;
  logic              w_wr_nxt;
  logic              w_frame_err_nxt;
  logic              w_overrun_nxt;

  assign w_rxs     = r_sync[1];
  assign w_bit_end = (r_cnt == CW'(CLKS_PER_BIT - 1));

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rxd};
    end
  end

  // State, datapath and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bidx      <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_wr        <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bidx      <= w_bidx_nxt;
      r_shift     <= w_shift_nxt;
      r_data      <= w_data_nxt;
      r_wr        <= w_wr_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_overrun   <= w_overrun_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Next-state and strobe decode; disable overrides everything and discards a partial frame.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bidx_nxt      = r_bidx;
    w_shift_nxt     = r_shift;
    w_data_nxt      = r_data;
    w_wr_nxt        = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_overrun_nxt   = 1'b0;

    if (!en) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_bidx_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (!w_rxs) begin
            w_state_nxt = S_START;
          end
        end
        S_START: begin
          if (r_cnt == CW'(HALF - 1)) begin
            w_cnt_nxt   = '0;
            w_bidx_nxt  = '0;
            w_state_nxt = w_rxs ? S_IDLE : S_DATA;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            w_cnt_nxt   = '0;
            w_shift_nxt = {w_rxs, r_shift[DWIDTH-1:1]};
            if (r_bidx == BW'(DWIDTH - 1)) begin
              w_bidx_nxt  = '0;
              w_state_nxt = S_STOP;
            end else begin
              w_bidx_nxt = r_bidx + BW'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            w_cnt_nxt = '0;
            if (w_rxs) begin
              w_state_nxt = S_IDLE;
              if (full) begin
                w_overrun_nxt = 1'b1;
              end else begin
                w_wr_nxt   = 1'b1;
                w_data_nxt = r_shift;
              end
            end else begin
              w_frame_err_nxt = 1'b1;
              w_state_nxt     = S_BREAK;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_BREAK: begin
          w_cnt_nxt = '0;
          if (w_rxs) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_bidx_nxt  = '0;
        end
      endcase
    end
  end

  assign wr        = r_wr;
  assign data      = r_data;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Directed bench for uart_rx_fifo_writer; expected strobes are queued as frames are
// driven and a negedge monitor matches each DUT strobe against the queue.
module tb_uart_rx_fifo_writer;

  localparam int unsigned DW   = 8;
  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = CPB / 2;

  localparam logic [1:0] K_WR = 2'd1;
  localparam logic [1:0] K_FE = 2'd2;
  localparam logic [1:0] K_OV = 2'd3;

  typedef struct packed {
    logic [1:0]    kind;
    logic [DW-1:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          rxd;
  logic          full;
  logic          wr;
  logic [DW-1:0] data;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  exp_t          exp_q[$];
  int            n_asserts = 0;
  int            n_fail    = 0;
  int            cyc_n     = 0;
  int            busy_rise = 0;
  int            last_lat  = -1;
  logic          busy_q    = 1'b0;
  logic [DW-1:0] last_data = '0;
  logic [1:0]    mon_kind;
  exp_t          mon_e;

  uart_rx_fifo_writer #(.DWIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rxd       (rxd),
    .full      (full),
    .wr        (wr),
    .data      (data),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [DW-1:0] d);
    exp_t e;
    e.kind = k;
    e.d    = d;
    exp_q.push_back(e);
  endtask

  // One serial bit lasting n clocks, changed on the falling edge.
  task automatic drive_bit(input logic b, input int n, input logic f);
    @(negedge clk);
    rxd  = b;
    full = f;
    repeat (n - 1) @(negedge clk);
  endtask

  // full_mode: 0 never full, 1 full during stop bit, 2 full during data bits only.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop_b, input int full_mode);
    drive_bit(1'b0, CPB, 1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i], CPB, full_mode == 2);
    drive_bit(stop_b, CPB, full_mode == 1);
    full = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    @(negedge clk);
    rxd = 1'b1;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 4 * CPB) begin
      @(negedge clk);
      k++;
    end
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Strobe monitor and data-hold checker.
  always @(negedge clk) begin
    if (rst) begin
      last_data = data;
      busy_q    = busy;
    end else begin
      cyc_n++;
      if (busy && !busy_q) busy_rise = cyc_n;
      busy_q = busy;
      if (wr || frame_err || overrun) begin
        chk("strobe_exclusive", 32'(int'(wr) + int'(frame_err) + int'(overrun)), 32'd1);
        mon_kind = wr ? K_WR : (frame_err ? K_FE : K_OV);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 32'(mon_kind), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("strobe_kind", 32'(mon_kind), 32'(mon_e.kind));
          if (wr) begin
            chk("wr_data", 32'(data), 32'(mon_e.d));
            chk("busy_low_at_wr", 32'(busy), 32'd0);
          end
          last_lat = cyc_n - busy_rise;
        end
      end
      if (!wr) chk("data_hold", 32'(data), 32'(last_data));
      last_data = data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    rxd  = 1'b1;
    full = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_fe", 32'(frame_err), 32'd0);
    chk("rst_ov", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    idle_cycles(CPB);

    // Single frame with stop-sample latency check.
    push(K_WR, 8'hA5);
    send_frame(8'hA5, 1'b1, 0);
    wait_drain();
    chk("stop_latency", 32'(last_lat), 32'(HALF + (DW + 1) * CPB));
    chk("busy_after_frame", 32'(busy), 32'd0);
    idle_cycles(CPB);

    // Back-to-back frames, no idle gap.
    push(K_WR, 8'h00);
    push(K_WR, 8'hFF);
    push(K_WR, 8'h3C);
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    send_frame(8'h3C, 1'b1, 0);
    wait_drain();
    idle_cycles(CPB);

    // Glitch shorter than half a bit.
    @(negedge clk);
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch_busy_mid", 32'(busy), 32'd1);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_busy_after", 32'(busy), 32'd0);
    push(K_WR, 8'h81);
    send_frame(8'h81, 1'b1, 0);
    wait_drain();
    idle_cycles(CPB);

    // Framing error with line held low afterwards.
    push(K_FE, 8'h00);
    send_frame(8'h55, 1'b0, 0);
    drive_bit(1'b0, 40, 1'b0);
    chk("break_busy_held", 32'(busy), 32'd1);
    wait_drain();
    @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    chk("break_busy_released", 32'(busy), 32'd0);
    idle_cycles(CPB);
    push(K_WR, 8'h12);
    send_frame(8'h12, 1'b1, 0);
    wait_drain();
    idle_cycles(CPB);

    // full during data bits only must not matter.
    push(K_WR, 8'h5A);
    send_frame(8'h5A, 1'b1, 2);
    wait_drain();
    idle_cycles(CPB);

    // Overrun: full at stop sample.
    push(K_OV, 8'h00);
    send_frame(8'h7E, 1'b1, 1);
    wait_drain();
    chk("overrun_data_held", 32'(data), 32'h5A);
    idle_cycles(CPB);

    // Reset during data bit 3.
    drive_bit(1'b0, CPB, 1'b0);
    drive_bit(1'b1, CPB, 1'b0);
    drive_bit(1'b0, CPB, 1'b0);
    drive_bit(1'b1, CPB, 1'b0);
    drive_bit(1'b1, HALF, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_wr", 32'(wr), 32'd0);
    chk("midrst_fe", 32'(frame_err), 32'd0);
    chk("midrst_ov", 32'(overrun), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_data", 32'(data), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_cycles(3 * CPB);
    chk("midrst_idle", 32'(busy), 32'd0);

    // en dropped mid-frame, then clean receive after re-enable.
    drive_bit(1'b0, CPB, 1'b0);
    drive_bit(1'b0, CPB, 1'b0);
    drive_bit(1'b1, HALF, 1'b0);
    chk("en_busy_before", 32'(busy), 32'd1);
    en = 1'b0;
    @(negedge clk);
    chk("en_drop_idle", 32'(busy), 32'd0);
    idle_cycles(2 * CPB);
    chk("en_low_idle", 32'(busy), 32'd0);
    en = 1'b1;
    idle_cycles(CPB);
    push(K_WR, 8'hC3);
    send_frame(8'hC3, 1'b1, 0);
    wait_drain();
    idle_cycles(CPB);
    chk("final_data", 32'(data), 32'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo_writer.md
# uart_rx_fifo_writer

Serial receiver that sits directly upstream of the team's synchronous FIFO. It oversamples an asynchronous UART line (8N1 by default), deserialises each frame LSB-first, and pushes each good byte into the FIFO with a single-cycle write strobe. It never writes while the FIFO reports full; it flags such drops as overrun. Stop-bit violations are flagged as framing errors.

## Interface
- `DWIDTH`, default 8: data bits per frame; equals the FIFO data width.
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit; must be ≥ 4. `HALF = CLKS_PER_BIT/2`, integer division.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  receive enable. When low, the FSM returns to IDLE at the next edge and no strobes are issued.
- `rxd`  in  1  asynchronous serial input; idles high.
- `full`  in  1  FIFO full flag.
- `wr`  out  1  FIFO write strobe; one-cycle pulse.
- `data`  out  DWIDTH  byte presented to the FIFO `dataIn`.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a good byte is dropped because `full` is high.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **Input sync:** `rxd` passes through a 2-flop synchroniser, reset to 1. All decisions use the synchronised value `rxs`.
- **Bit counter:** `cnt` is ceil(log2(CLKS_PER_BIT)) bits wide and reset to 0 on every state entry. The data-bit index runs 0..DWIDTH-1.
- **IDLE:** if `en` and `rxs`==0, go to START.
- **START:** increment `cnt` each cycle. At `cnt`==HALF-1, sample `rxs`.
  - `rxs`==1: glitch. Return to IDLE with no flags.
  - `rxs`==0: go to DATA.
- **DATA:** sample at `cnt`==CLKS_PER_BIT-1. The sample shifts into the shift register MSB end (right shift, LSB-first on the line). After DWIDTH samples, go to STOP.
- **STOP:** sample at `cnt`==CLKS_PER_BIT-1.
  - `rxs`==1 and `full`==0: load `data` from the shift register, pulse `wr`, go to IDLE.
  - `rxs`==1 and `full`==1: pulse `overrun`; `data` and the FIFO are untouched; go to IDLE.
  - `rxs`==0: pulse `frame_err`, no write, go to BREAK.
- **BREAK:** wait for `rxs`==1, then go to IDLE. This keeps a held-low line from being taken as repeated starts.
- **`en` deassertion:** in any state, `en` low forces IDLE at the next edge. A partial frame is discarded silently.
- **Strobe exclusivity:** `wr`, `frame_err` and `overrun` are mutually exclusive.
- **`data` hold:** `data` changes only in the cycle `wr` is asserted. It holds its value otherwise.
- **Reset:** reset values are `wr`=0, `frame_err`=0, `overrun`=0, `busy`=0, `data`=0, FSM=IDLE, `cnt`=0, shift register=0, synchroniser=1. Reset mid-frame abandons the frame with no strobe.

## Timing
- **Synchroniser latency:** a falling edge on `rxd` reaches `rxs` 2 cycles later. START is entered on the edge after `rxs` goes low.
- **Sample points:** let E be the entry edge into START.
  - Start-bit sample: at E+HALF.
  - Data bit k: at E+HALF+(k+1)·CLKS_PER_BIT.
  - Stop bit: at E+HALF+(DWIDTH+1)·CLKS_PER_BIT.
- **Strobes are registered:** `wr`, `overrun` or `frame_err` is high for exactly the one cycle following the stop-sample edge. `data` is valid in that same cycle and after it.
- **`full` sampling:** `full` is sampled on the stop-sample edge only. Changes to `full` at any other time have no effect.
- **Back-to-back frames:** after a good stop bit the FSM is in IDLE half a bit early. A start bit immediately following is therefore caught with no lost frame.
- **Throughput:** at most one `wr` per DWIDTH+2 bit times. This is compatible with the FIFO accepting `wr` every cycle.

## Test plan
- **Single frame:** reset, `en`=1, `full`=0, send 0xA5 at 16 clk/bit. Require `wr` high for exactly 1 cycle, `data`=0xA5, stop sample 152 cycles after START entry, `busy` low the cycle after.
- **Back-to-back:** send 0x00, 0xFF and 0x3C with no idle gap. Require three `wr` pulses with `data` 0x00, 0xFF, 0x3C in order and no `frame_err`.
- **Glitch rejection:** drive `rxd` low for 5 cycles, then high. Require return to IDLE with no strobes. A following 0x81 frame is received correctly.
- **Framing error:** send 0x55 with the stop bit low and the line held low 40 more cycles. Require one `frame_err` pulse, no `wr`, `busy` high until `rxs` rises, then a next frame 0x12 received.
- **Overrun:** `full`=1 during the stop sample of 0x7E. Require one `overrun` pulse, no `wr`, `data` still holding the previous byte.
- **Reset / `en` mid-frame:**
  - Assert `rst` during bit 3 of a frame. Require all outputs at reset values immediately and no strobe.
  - Drop `en` mid-frame. Require IDLE at the next edge, no strobe, and a clean receive after re-enable.
